bellek_asamasi: RTL
===================

BELLEK_ASAMASI -- requirements
Module: bellek_asamasi

Interface
REQ-001 SHALL have port clk_i, in, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, in, 1: reset, synchronous, active-high.
REQ-003 SHALL have port bellek_uop_i, in, UOP_BIT: uop from execute stage. Fields used: VALID, RD (effective address or result), RS2 (store data), BEL (memory op), RD_ADDR, TAG, PC.
REQ-004 SHALL have port duraklat_o, out, 1: stall request to upstream stages.
REQ-005 SHALL have port istek_adres_o, out, 32: data-memory word address.
REQ-006 SHALL have port istek_veri_o, out, 32: store data.
REQ-007 SHALL have port istek_maske_o, out, 4: byte write mask.
REQ-008 SHALL have port istek_yaz_o, out, 1: 1 = store, 0 = load.
REQ-009 SHALL have port istek_gecerli_o, out, 1: request valid.
REQ-010 SHALL have port istek_hazir_i, in, 1: memory accepts the request.
REQ-011 SHALL have port yanit_veri_i, in, 32: load data word.
REQ-012 SHALL have port yanit_gecerli_i, in, 1: load data valid.
REQ-013 SHALL have ports ddb_odd_ps_o (PS_BIT), ddb_odd_kod_o (EXC_CODE_BIT), ddb_odd_bilgi_o (32), ddb_odd_gecerli_o (1), all out: exception report.
REQ-014 SHALL have ports yo_veri_o (32), yo_adres_o (YAZMAC_BIT), yo_etiket_o (UOP_TAG_BIT), yo_gecerli_o (1), all out: forwarding of the registered result.
REQ-015 SHALL have port geriyaz_uop_o, out, UOP_BIT: registered uop to writeback.

Function
REQ-016 SHALL implement FSM states BOSTA, ISTEK and YANIT.
REQ-017 A valid non-memory uop SHALL pass to geriyaz_uop_o with 1-cycle latency and RD unchanged.
REQ-018 In BOSTA, a valid aligned memory op SHALL assert istek_gecerli_o combinationally in the same cycle, with address = RD & ~3.
REQ-019 Request accepted when istek_gecerli_o && istek_hazir_i: a store completes that cycle; a load moves to YANIT.
REQ-020 Request not accepted: FSM SHALL move to ISTEK; request outputs SHALL stay asserted and unchanged until accepted.
REQ-021 In YANIT, the load completes in the cycle yanit_gecerli_i=1; FSM SHALL return to BOSTA.
REQ-022 yanit_gecerli_i SHALL be ignored in BOSTA and ISTEK.
REQ-023 duraklat_o SHALL be 1 in every cycle a valid memory op has not completed, including the request cycle when not accepted and every YANIT cycle without a response; it SHALL be 0 in the completing cycle.
REQ-024 While duraklat_o=1, geriyaz_uop_o SHALL register a bubble (VALID=0). Upstream holds bellek_uop_i stable during this time.
REQ-025 Store mask SHALL be: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],0}; SW = 1111.
REQ-026 Store data SHALL be: byte replicated x4, half replicated x2, word as-is.
REQ-027 Load formatting SHALL be: LB/LBU select the byte at addr[1:0], sign-/zero-extended; LH/LHU select the half at addr[1]; LW passes the word. The result replaces RD.
REQ-028 Misalignment (half with addr[0]=1; word with addr[1:0]!=0) SHALL issue no request and SHALL pulse ddb_odd_gecerli_o for one cycle with kod=4 (load) or 6 (store), bilgi = address, ps = PC. The uop SHALL be forwarded with VALID=0.
REQ-029 yo_gecerli_o SHALL equal geriyaz_uop_o VALID AND (the op writes rd); yo_veri_o, yo_adres_o and yo_etiket_o SHALL come from geriyaz_uop_o.

Reset
REQ-030 On rst_i=1 at a clock edge, FSM SHALL go to BOSTA and geriyaz_uop_o SHALL clear to all-zero. istek_gecerli_o, duraklat_o, ddb_odd_gecerli_o and yo_gecerli_o SHALL then be 0.
REQ-031 Reset during ISTEK or YANIT SHALL abandon the access; a late yanit_gecerli_i SHALL be ignored.

Structure
REQ-032 BEL op encodings (NOP, LB, LH, LW, LBU, LHU, SB, SH, SW) and EXC codes 4 and 6 SHALL reside in the shared sabitler/mikroislem headers.
REQ-033 Load extraction and extension SHALL be one sub-module: yukle_bicimlendir.

Verification
REQ-034 Scenario: SW addr 0x100, data 0xDEADBEEF, hazir=1 -> single-cycle request, mask 1111, duraklat_o=0, uop out next cycle.
REQ-035 Scenario: LB addr 0x203, memory word 0x80xxxxxx, hazir after 2 cycles, response 3 cycles later -> duraklat_o high 5 cycles, RD=0xFFFFFF80.
REQ-036 Scenario: LHU addr 0x202, word 0xBEEF1234 -> RD=0x0000BEEF.
REQ-037 Scenario: SH addr 0x301 -> no request, kod=6, bilgi=0x301, output VALID=0.
REQ-038 Scenario: rst_i asserted in YANIT, then yanit_gecerli_i arrives -> state BOSTA, no output uop, outputs zero.
REQ-039 Scenario: ADD uop followed by LW with immediate response -> back-to-back outputs, yo_gecerli_o for both.

Source files
------------

// File: rtl/bellek_asamasi_pkg.sv
// Shared constants, uop layout and byte-lane helpers for the memory stage.
package bellek_asamasi_pkg;

    localparam int VERI_BIT     = 32;
    localparam int MASKE_BIT    = 4;
    localparam int PS_BIT       = 32;
    localparam int EXC_CODE_BIT = 5;
    localparam int YAZMAC_BIT   = 5;
    localparam int UOP_TAG_BIT  = 4;

    // Exception codes reported for misaligned accesses
    localparam logic [EXC_CODE_BIT-1:0] EXC_YUKLEME_HIZASIZ = 5'd4;
    localparam logic [EXC_CODE_BIT-1:0] EXC_SAKLAMA_HIZASIZ = 5'd6;

    typedef enum logic [3:0] {
        BEL_NOP = 4'd0,
        BEL_LB  = 4'd1,
        BEL_LH  = 4'd2,
        BEL_LW  = 4'd3,
        BEL_LBU = 4'd4,
        BEL_LHU = 4'd5,
        BEL_SB  = 4'd6,
        BEL_SH  = 4'd7,
        BEL_SW  = 4'd8
    } bel_e;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        YANIT = 2'd2
    } durum_e;

    // rd carries the effective address on the way in and the result on the way out
    typedef struct packed {
        logic                   valid;
        logic [PS_BIT-1:0]      pc;
        logic [UOP_TAG_BIT-1:0] tag;
        logic [YAZMAC_BIT-1:0]  rd_addr;
        logic                   rd_yaz;
        bel_e                   bel;
        logic [VERI_BIT-1:0]    rs2;
        logic [VERI_BIT-1:0]    rd;
    } uop_t;

    function automatic logic bellek_islemi_mi(bel_e b);
        case (b)
            BEL_LB, BEL_LH, BEL_LW, BEL_LBU, BEL_LHU,
            BEL_SB, BEL_SH, BEL_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic yukleme_mi(bel_e b);
        case (b)
            BEL_LB, BEL_LH, BEL_LW, BEL_LBU, BEL_LHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic hizasiz_mi(bel_e b, logic [1:0] a);
        case (b)
            BEL_LH, BEL_LHU, BEL_SH: return a[0];
            BEL_LW, BEL_SW:          return (a != 2'b00);
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [MASKE_BIT-1:0] saklama_maskesi(bel_e b, logic [1:0] a);
        case (b)
            BEL_SB:  return 4'b0001 << a;
            BEL_SH:  return 4'b0011 << {a[1], 1'b0};
            BEL_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [VERI_BIT-1:0] saklama_verisi(bel_e b, logic [VERI_BIT-1:0] d);
        case (b)
            BEL_SB:  return {4{d[7:0]}};
            BEL_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/bellek_asamasi_if.sv
// Data-memory request/response bus between the memory stage and the memory.
interface bellek_asamasi_if;
    import bellek_asamasi_pkg::*;

    logic [VERI_BIT-1:0]  istek_adres;
    logic [VERI_BIT-1:0]  istek_veri;
    logic [MASKE_BIT-1:0] istek_maske;
    logic                 istek_yaz;
    logic                 istek_gecerli;
    logic                 istek_hazir;
    logic [VERI_BIT-1:0]  yanit_veri;
    logic                 yanit_gecerli;

    modport master (
        output istek_adres, istek_veri, istek_maske, istek_yaz, istek_gecerli,
        input  istek_hazir, yanit_veri, yanit_gecerli
    );

    modport slave (
        input  istek_adres, istek_veri, istek_maske, istek_yaz, istek_gecerli,
        output istek_hazir, yanit_veri, yanit_gecerli
    );
endinterface

// File: rtl/bellek_asamasi_yukle_bicimlendir.sv
// Picks the addressed byte/half out of a loaded word and extends it to 32 bits.
module yukle_bicimlendir
    import bellek_asamasi_pkg::*;
(
    input  bel_e                bel_i,
    input  logic [1:0]          adres_i,
    input  logic [VERI_BIT-1:0] veri_i,
    output logic [VERI_BIT-1:0] sonuc_o
);

    logic [7:0]  bayt_s;
    logic [15:0] yarim_s;

    // Lane selection followed by sign or zero extension
    always_comb begin
        bayt_s  = 8'h00;
        yarim_s = 16'h0000;
        sonuc_o = veri_i;
        case (adres_i)
            2'd0:    bayt_s = veri_i[7:0];
            2'd1:    bayt_s = veri_i[15:8];
            2'd2:    bayt_s = veri_i[23:16];
            2'd3:    bayt_s = veri_i[31:24];
            default: bayt_s = 8'h00;
        endcase
        if (adres_i[1]) begin
            yarim_s = veri_i[31:16];
        end else begin
            yarim_s = veri_i[15:0];
        end
        case (bel_i)
            BEL_LB:  sonuc_o = {{24{bayt_s[7]}}, bayt_s};
            BEL_LBU: sonuc_o = {24'h000000, bayt_s};
            BEL_LH:  sonuc_o = {{16{yarim_s[15]}}, yarim_s};
            BEL_LHU: sonuc_o = {16'h0000, yarim_s};
            default: sonuc_o = veri_i;
        endcase
    end

endmodule

// File: rtl/bellek_asamasi.sv
// Memory stage: issues loads/stores, stalls upstream until they complete,
// reports misaligned accesses and registers the uop for writeback.
module bellek_asamasi
    import bellek_asamasi_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  uop_t                    bellek_uop_i,
    output logic                    duraklat_o,
    bellek_asamasi_if.master        bellek,
    output logic [PS_BIT-1:0]       ddb_odd_ps_o,
    output logic [EXC_CODE_BIT-1:0] ddb_odd_kod_o,
    output logic [VERI_BIT-1:0]     ddb_odd_bilgi_o,
    output logic                    ddb_odd_gecerli_o,
    output logic [VERI_BIT-1:0]     yo_veri_o,
    output logic [YAZMAC_BIT-1:0]   yo_adres_o,
    output logic [UOP_TAG_BIT-1:0]  yo_etiket_o,
    output logic                    yo_gecerli_o,
    output uop_t                    geriyaz_uop_o
);

    durum_e                  durum_r;
    durum_e                  durum_sonraki_s;
    uop_t                    geriyaz_r;
    uop_t                    geriyaz_sonraki_s;
    logic                    ddb_gecerli_r;
    logic [EXC_CODE_BIT-1:0] ddb_kod_r;
    logic [VERI_BIT-1:0]     ddb_bilgi_r;
    logic [PS_BIT-1:0]       ddb_ps_r;
    logic                    bellek_op_s;
    logic                    yukleme_s;
    logic                    hizasiz_s;
    logic                    istek_gecerli_s;
    logic                    duraklat_s;
    logic [VERI_BIT-1:0]     yuklenen_s;

    assign bellek_op_s = bellek_uop_i.valid && bellek_islemi_mi(bellek_uop_i.bel);
    assign yukleme_s   = yukleme_mi(bellek_uop_i.bel);

    yukle_bicimlendir u_yukle_bicimlendir (
        .bel_i   (bellek_uop_i.bel),
        .adres_i (bellek_uop_i.rd[1:0]),
        .veri_i  (bellek.yanit_veri),
        .sonuc_o (yuklenen_s)
    );

    // Next state, stall, request strobe and the uop to be registered
    always_comb begin
        durum_sonraki_s         = durum_r;
        istek_gecerli_s         = 1'b0;
        duraklat_s              = 1'b0;
        hizasiz_s               = 1'b0;
        geriyaz_sonraki_s       = bellek_uop_i;
        geriyaz_sonraki_s.valid = 1'b0;
        case (durum_r)
            BOSTA: begin
                if (bellek_op_s) begin
                    if (hizasiz_mi(bellek_uop_i.bel, bellek_uop_i.rd[1:0])) begin
                        hizasiz_s = 1'b1;
                    end else begin
                        istek_gecerli_s = 1'b1;
                        if (bellek.istek_hazir) begin
                            if (yukleme_s) begin
                                durum_sonraki_s = YANIT;
                                duraklat_s      = 1'b1;
                            end else begin
                                geriyaz_sonraki_s.valid = 1'b1;
                            end
                        end else begin
                            durum_sonraki_s = ISTEK;
                            duraklat_s      = 1'b1;
                        end
                    end
                end else begin
                    geriyaz_sonraki_s.valid = bellek_uop_i.valid;
                end
            end
            ISTEK: begin
                istek_gecerli_s = 1'b1;
                if (bellek.istek_hazir) begin
                    if (yukleme_s) begin
                        durum_sonraki_s = YANIT;
                        duraklat_s      = 1'b1;
                    end else begin
                        durum_sonraki_s         = BOSTA;
                        geriyaz_sonraki_s.valid = 1'b1;
                    end
                end else begin
                    duraklat_s = 1'b1;
                end
            end
            YANIT: begin
                if (bellek.yanit_gecerli) begin
                    durum_sonraki_s         = BOSTA;
                    geriyaz_sonraki_s.valid = 1'b1;
                    geriyaz_sonraki_s.rd    = yuklenen_s;
                end else begin
                    duraklat_s = 1'b1;
                end
            end
            default: begin
                durum_sonraki_s = BOSTA;
            end
        endcase
    end

    // State, writeback uop and exception report registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_r       <= BOSTA;
            geriyaz_r     <= '0;
            ddb_gecerli_r <= 1'b0;
            ddb_kod_r     <= '0;
            ddb_bilgi_r   <= '0;
            ddb_ps_r      <= '0;
        end else begin
            durum_r       <= durum_sonraki_s;
            geriyaz_r     <= geriyaz_sonraki_s;
            ddb_gecerli_r <= hizasiz_s;
            if (hizasiz_s) begin
                ddb_kod_r   <= yukleme_s ? EXC_YUKLEME_HIZASIZ : EXC_SAKLAMA_HIZASIZ;
                ddb_bilgi_r <= bellek_uop_i.rd;
                ddb_ps_r    <= bellek_uop_i.pc;
            end
        end
    end

    assign bellek.istek_gecerli = istek_gecerli_s;
    assign bellek.istek_adres   = {bellek_uop_i.rd[31:2], 2'b00};
    assign bellek.istek_veri    = saklama_verisi(bellek_uop_i.bel, bellek_uop_i.rs2);
    assign bellek.istek_maske   = saklama_maskesi(bellek_uop_i.bel, bellek_uop_i.rd[1:0]);
    assign bellek.istek_yaz     = ~yukleme_s;

    assign duraklat_o        = duraklat_s;
    assign geriyaz_uop_o     = geriyaz_r;
    assign ddb_odd_gecerli_o = ddb_gecerli_r;
    assign ddb_odd_kod_o     = ddb_kod_r;
    assign ddb_odd_bilgi_o   = ddb_bilgi_r;
    assign ddb_odd_ps_o      = ddb_ps_r;
    assign yo_gecerli_o      = geriyaz_r.valid & geriyaz_r.rd_yaz;
    assign yo_veri_o         = geriyaz_r.rd;
    assign yo_adres_o        = geriyaz_r.rd_addr;
    assign yo_etiket_o       = geriyaz_r.tag;

endmodule
